dmem_responder: RTL and testbench

// Data-memory responder: the slave end of the processor's load/store port. Accepts one

---
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with fixed wait states, byte-enabled stores and address error flagging
// Ports:
//   clk    - clock, all state changes on posedge
//   rst_n  - asynchronous active-low reset (memory contents are kept)
//   req    - access request, held by the initiator until ack
//   we     - 1 = store, 0 = load, sampled with req in IDLE
//   addr   - word-aligned byte address
//   wdata  - store data, byte k = wdata[8k+7:8k]
//   be     - store byte enables, ignored for loads
//   ack    - one-cycle completion pulse; rdata/err valid with it
//   rdata  - load data (0 on error or store)
//   err    - misaligned or out-of-range address, valid with ack
//   busy   - a captured request is outstanding
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);
   localparam int NB = 4 * DEPTH_WORDS;
   localparam int AW = $clog2(NB);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [31:0] addr_q, wdata_q, cur_addr, rd_word;
   logic [3:0]  be_q;
   logic        we_q, cur_we, cur_bad, bad_q;
   logic [7:0]  bytes [0:NB-1];

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(NB));
   endfunction

   // With zero wait states the read happens on the capture edge, so the
   // address comes straight from the port instead of the capture register.
   always_comb begin
      cur_addr = (state == IDLE) ? addr : addr_q;
      cur_we   = (state == IDLE) ? we : we_q;
      cur_bad  = bad_addr(cur_addr);
      bad_q    = bad_addr(addr_q);
      rd_word  = {bytes[{cur_addr[AW-1:2], 2'd3}], bytes[{cur_addr[AW-1:2], 2'd2}],
                  bytes[{cur_addr[AW-1:2], 2'd1}], bytes[{cur_addr[AW-1:2], 2'd0}]};
      state_nx = (state == IDLE) ? (req ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE) :
                 (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT) : IDLE;
      ack      = (state == RESP);
      err      = ack && bad_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         rdata   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            we_q    <= we;
            busy    <= 1'b1;
            cnt     <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == RESP)
            busy <= 1'b0;
         if (state_nx == RESP && state != RESP)
            rdata <= (cur_we || cur_bad) ? 32'd0 : rd_word;
      end
   end

   // Storage is deliberately not reset; an async reset forces state to IDLE,
   // which blocks any pending commit.
   always_ff @(posedge clk) begin
      if (state == RESP && we_q && !bad_q)
         for (int k = 0; k < 4; k++)
            if (be_q[k])
               bytes[{addr_q[AW-1:2], 2'(k)}] <= wdata_q[8*k +: 8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 side instance)
module tb_dmem_responder;
   localparam int WS = 2;
   localparam int DEPTH = 256;
   localparam int NB = 4 * DEPTH;

   typedef struct {
      int          c;
      bit          e;
      bit          w;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        ack, err, busy;
   logic [31:0] rdata;
   logic        req0 = 1'b0;
   logic [31:0] addr0 = '0;
   logic        ack0, err0, busy0;
   logic [31:0] rdata0;

   int          cyc = 0;
   int          compared = 0, mismatched = 0;
   int          next_cap = 0;
   exp_t        sb[$];
   logic [7:0]  mref [0:NB-1];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .we(1'b0), .addr(addr0), .wdata(32'd0),
      .be(4'd0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mword(input int a);
      return {mref[a+3], mref[a+2], mref[a+1], mref[a]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (ack) begin
         if (sb.size() == 0) begin
            check("spurious_ack", {31'd0, ack}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("ack_cycle", cyc, e.c);
            check("err", {31'd0, err}, {31'd0, e.e});
            if (!e.w || e.e)
               check("rdata", rdata, e.d);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: the access is applied to the byte array when issued,
   // which is exact because the responder serializes accesses.
   task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit drop);
      int   cap;
      exp_t x;
      cap = (cyc + 1 > next_cap) ? cyc + 1 : next_cap;
      x.c = cap + WS;
      x.e = (a[1:0] != 2'b00) || (a >= 32'(NB));
      x.w = w;
      x.d = '0;
      if (!x.e && !w)
         x.d = mword(int'(a));
      if (!x.e && w)
         for (int k = 0; k < 4; k++)
            if (b[k])
               mref[int'(a) + k] = d[8*k +: 8];
      sb.push_back(x);
      next_cap = cap + WS + 2;
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      if (drop) begin
         while (cyc < cap) begin
            @(posedge clk);
            #1;
         end
         req = 1'b0;
      end
      while (cyc <= x.c) begin
         @(posedge clk);
         #1;
      end
      req = 1'b0;
   endtask

   task automatic poke(input int a, input logic [31:0] v);
      for (int k = 0; k < 4; k++) begin
         mref[a+k] = v[8*k +: 8];
         dut.bytes[a+k] = v[8*k +: 8];
         dut0.bytes[a+k] = v[8*k +: 8];
      end
   endtask

   initial begin
      logic [7:0]  v;
      logic [31:0] a;
      for (int i = 0; i < NB; i++) begin
         v = 8'($urandom);
         mref[i] = v;
         dut.bytes[i] = v;
         dut0.bytes[i] = v;
      end
      poke(32'h04, 32'hDEADBEEF);
      poke(32'h08, 32'h11223344);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      idle(1);

      // zero-wait-state instance: 8 back-to-back loads in 16 cycles
      req0 = 1'b1;
      addr0 = 32'd0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         check("ws0_ack", {31'd0, ack0}, 32'(j % 2));
         if (j % 2 == 1) begin
            if (ack0)
               check("ws0_rdata", rdata0, mword((j / 2) * 4));
            addr0 = 32'(((j + 1) / 2) * 4);
            req0 = (j < 15);
         end
      end
      idle(3);
      check("ws0_quiet", {31'd0, busy0}, 32'd0);

      // reset in the middle of a store's wait phase
      req = 1'b1; we = 1'b1; addr = 32'h10; wdata = $urandom; be = 4'hF;
      idle(1);
      check("wait_busy", {31'd0, busy}, 32'd1);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      check("async_ack", {31'd0, ack}, 32'd0);
      check("async_err", {31'd0, err}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      next_cap = 0;
      idle(1);
      access(0, 32'h10, 0, 0, 0);

      access(0, 32'h04, 0, 0, 0);
      access(1, 32'h08, 32'hAABBCCDD, 4'b0101, 0);
      access(0, 32'h08, 0, 0, 0);
      access(0, 32'h06, 0, 0, 0);
      access(1, 32'h400, $urandom, 4'hF, 0);
      access(1, 32'h3FE, $urandom, 4'hF, 0);
      access(0, 32'h3FC, 0, 0, 0);
      access(0, 32'hFFFFFFFC, 0, 0, 0);
      access(1, 32'h0C, $urandom, 4'h0, 0);
      access(0, 32'h0C, 0, 0, 0);
      idle(2);
      access(1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
      access(0, 32'h20, 0, 0, 0);
      idle(1);
      access(0, 32'h04, 0, 0, 1);
      idle(4);

      for (int i = 0; i < 300; i++) begin
         case ($urandom % 8)
            0: a = $urandom;
            1: a = 32'(NB) + 32'($urandom_range(0, 63) * 4);
            2, 3, 4: a = 32'($urandom_range(0, 15) * 4);
            default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
         endcase
         access(1'($urandom), a, $urandom, 4'($urandom), ($urandom % 10) == 0);
         idle($urandom % 3);
      end
      for (int i = 0; i < 16; i++)
         access(0, 32'(i * 4), 0, 0, 0);

      idle(WS + 4);
      check("pending", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
